// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ readout path: host command codes, framing
// tags and the readout FSM state encoding.
package daq_pkg;

  localparam logic [7:0]  CMD_START = 8'h01;
  localparam logic [7:0]  CMD_ABORT = 8'h02;
  localparam logic [15:0] HDR_TAG   = 16'hA5A5;
  localparam logic [15:0] TRL_TAG   = 16'h5A5A;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LO    = 3'd4,
    ST_HI    = 3'd5,
    ST_TRL   = 3'd6
  } state_e;

  // Trailer half-word: tag, zero byte, number of 64-bit words in the event.
  function automatic logic [31:0] trl_word(input logic [7:0] n_words);
    return {TRL_TAG, 8'h00, n_words};
  endfunction

endpackage

// File: rtl/event_readout_if.sv
// FIFO read port plus the outgoing half-word stream of the event readout.
interface event_readout_if;

  logic        rd_en_o;
  logic        empty_i;
  logic [63:0] dout_i;
  logic [31:0] event_half_o;
  logic        half_valid_o;
  logic        half_ready_i;

  modport master (
    output rd_en_o, event_half_o, half_valid_o,
    input  empty_i, dout_i, half_ready_i
  );

  modport slave (
    input  rd_en_o, event_half_o, half_valid_o,
    output empty_i, dout_i, half_ready_i
  );

endinterface

// File: rtl/event_readout_cmd_edge_det.sv
// Host command decoder: start fires only on the first cycle of CMD_START,
// abort fires on every cycle CMD_ABORT is present.
module cmd_edge_det
  import daq_pkg::*;
(
  input  logic       clk_125,
  input  logic       rst,
  input  logic [7:0] cmd,
  output logic       start,
  output logic       abort
);

  logic [7:0] cmd_q_r;

  // Previous-cycle command for edge detection
  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      cmd_q_r <= 8'h00;
    end else begin
      cmd_q_r <= cmd;
    end
  end

  // Pulse decode from current and previous command
  always_comb begin
    start = (cmd == CMD_START) && (cmd_q_r != CMD_START);
    abort = (cmd == CMD_ABORT);
  end

endmodule

// File: rtl/event_readout.sv
// Event readout: drains 64-bit FIFO words and streams each event as header,
// low/high payload half-words and trailer over a valid/ready handshake.
module event_readout
  import daq_pkg::*;
#(
  parameter int unsigned EVENT_WORDS = 16
)
(
  input  logic            clk_125,
  input  logic            rst,
  input  logic [7:0]      cmd,
  event_readout_if.master bus,
  output logic            busy_o,
  output logic [15:0]     event_cnt_o
);

  localparam logic [7:0] LAST_IDX = 8'(EVENT_WORDS - 1);
  localparam logic [7:0] WORDS_8  = 8'(EVENT_WORDS);

  state_e      state_r;
  state_e      state_nxt_s;
  logic        start_s;
  logic        abort_s;
  logic        valid_s;
  logic        rd_en_s;
  logic        accept_s;
  logic [31:0] half_s;
  logic [63:0] hold_r;
  logic [7:0]  word_cnt_r;
  logic [15:0] event_cnt_r;

  cmd_edge_det u_cmd_edge_det (
    .clk_125 (clk_125),
    .rst     (rst),
    .cmd     (cmd),
    .start   (start_s),
    .abort   (abort_s)
  );

  // FSM state register
  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output decode from registered state; read strobe is gated by empty
  always_comb begin
    valid_s = 1'b0;
    half_s  = 32'h0000_0000;
    rd_en_s = 1'b0;
    case (state_r)
      ST_HDR: begin
        valid_s = 1'b1;
        half_s  = {HDR_TAG, event_cnt_r};
      end
      ST_FETCH: rd_en_s = !bus.empty_i;
      ST_LO: begin
        valid_s = 1'b1;
        half_s  = hold_r[31:0];
      end
      ST_HI: begin
        valid_s = 1'b1;
        half_s  = hold_r[63:32];
      end
      ST_TRL: begin
        valid_s = 1'b1;
        half_s  = trl_word(WORDS_8);
      end
      default: begin
        valid_s = 1'b0;
        half_s  = 32'h0000_0000;
        rd_en_s = 1'b0;
      end
    endcase
    accept_s = valid_s && bus.half_ready_i;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (abort_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = start_s  ? ST_HDR   : ST_IDLE;
        ST_HDR:   state_nxt_s = accept_s ? ST_FETCH : ST_HDR;
        ST_FETCH: state_nxt_s = rd_en_s  ? ST_WAIT  : ST_FETCH;
        ST_WAIT:  state_nxt_s = ST_LO;
        ST_LO:    state_nxt_s = accept_s ? ST_HI    : ST_LO;
        ST_HI: begin
          if (accept_s) begin
            state_nxt_s = (word_cnt_r == LAST_IDX) ? ST_TRL : ST_FETCH;
          end else begin
            state_nxt_s = ST_HI;
          end
        end
        ST_TRL:   state_nxt_s = accept_s ? ST_IDLE  : ST_TRL;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Holding register: FIFO data is valid the cycle after the read strobe
  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      hold_r <= 64'h0;
    end else if (state_r == ST_WAIT) begin
      hold_r <= bus.dout_i;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Payload word counter within the current event
  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      word_cnt_r <= 8'h00;
    end else if (abort_s) begin
      word_cnt_r <= 8'h00;
    end else if ((state_r == ST_HI) && accept_s) begin
      word_cnt_r <= word_cnt_r + 8'h01;
    end else if ((state_r == ST_TRL) && accept_s) begin
      word_cnt_r <= 8'h00;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  // Completed-event counter, advanced only when the trailer is taken
  always_ff @(posedge clk_125 or negedge rst) begin
    if (!rst) begin
      event_cnt_r <= 16'h0000;
    end else if (!abort_s && (state_r == ST_TRL) && accept_s) begin
      event_cnt_r <= event_cnt_r + 16'h0001;
    end else begin
      event_cnt_r <= event_cnt_r;
    end
  end

  assign bus.rd_en_o      = rd_en_s;
  assign bus.half_valid_o = valid_s;
  assign bus.event_half_o = half_s;
  assign busy_o           = (state_r != ST_IDLE);
  assign event_cnt_o      = event_cnt_r;

endmodule

// File: tb/tb_event_readout.sv
// Scoreboard bench for event_readout: a FIFO model feeds words, the expected
// half-word stream of each event is queued at start, a monitor compares.
module tb_event_readout;
  import daq_pkg::*;

  localparam int NW = 16;

  logic        clk_125 = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic        busy_o;
  logic [15:0] event_cnt_o;

  event_readout_if bus_if();

  event_readout #(.EVENT_WORDS(NW)) dut (
    .clk_125     (clk_125),
    .rst         (rst),
    .cmd         (cmd),
    .bus         (bus_if),
    .busy_o      (busy_o),
    .event_cnt_o (event_cnt_o)
  );

  always #4 clk_125 = ~clk_125;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [63:0] fifo_q[$];
  logic [15:0] model_cnt = 16'h0000;
  int          rd_count = 0;
  int          acc_cnt = 0;
  int          starve_at = -1;
  int          starve_left = 0;
  int          ready_mode = 0;
  int          hold_after = 1000;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model and downstream ready driver, updated 1 unit after each edge
  initial begin : fifo_model
    logic rd_smp;
    logic r;
    bus_if.dout_i       = 64'h0;
    bus_if.half_ready_i = 1'b0;
    forever begin
      bus_if.empty_i = (fifo_q.size() == 0) || (starve_left > 0);
      @(posedge clk_125);
      rd_smp = bus_if.rd_en_o;
      if (rd_smp === 1'b1) check("rd_while_empty", {31'h0, bus_if.empty_i}, 32'h0);
      #1;
      cyc++;
      if (starve_left > 0) starve_left--;
      if ((rd_smp === 1'b1) && (fifo_q.size() > 0)) begin
        bus_if.dout_i = fifo_q.pop_front();
        rd_count++;
        if (rd_count == starve_at) starve_left = 20;
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 3) == 0);
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      if (acc_cnt >= hold_after) r = 1'b0;
      bus_if.half_ready_i = r;
    end
  end

  // Monitor: pops the scoreboard on every accepted half-word
  initial begin : monitor
    logic        stall_p;
    logic [31:0] val_p;
    logic [7:0]  cmd_p;
    stall_p = 1'b0;
    val_p   = 32'h0;
    cmd_p   = 8'h00;
    forever begin
      @(negedge clk_125);
      if (rst !== 1'b1) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p && (cmd_p != CMD_ABORT)) begin
          check("hold_valid", {31'h0, bus_if.half_valid_o}, 32'h1);
          check("hold_data", bus_if.event_half_o, val_p);
        end
        if (bus_if.half_valid_o && bus_if.half_ready_i) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_half: got %h expected none", bus_if.event_half_o);
          end else begin
            check("half_word", bus_if.event_half_o, exp_q.pop_front());
          end
        end
        if ((ready_mode == 0) && (starve_left > 0) && (starve_left <= 15))
          check("starve_no_valid", {31'h0, bus_if.half_valid_o}, 32'h0);
        stall_p = bus_if.half_valid_o && !bus_if.half_ready_i;
        val_p   = bus_if.event_half_o;
        cmd_p   = cmd;
      end
    end
  end

  task automatic tick();
    @(posedge clk_125);
    #2;
  endtask

  task automatic load_pattern();
    fifo_q.delete();
    for (int k = 0; k < NW; k++) fifo_q.push_back({32'(k), 32'h1000_0000 | 32'(k)});
  endtask

  task automatic load_random();
    fifo_q.delete();
    for (int k = 0; k < NW; k++) fifo_q.push_back({$urandom(), $urandom()});
  endtask

  // Queue the expected event from the FIFO contents, then issue CMD_START
  task automatic begin_event(input int hold_cycles);
    exp_q.push_back({16'hA5A5, model_cnt});
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(fifo_q[k][31:0]);
      exp_q.push_back(fifo_q[k][63:32]);
    end
    exp_q.push_back({16'h5A5A, 16'(NW)});
    model_cnt = model_cnt + 16'h0001;
    rd_count = 0;
    acc_cnt  = 0;
    cmd = CMD_START;
    tick();
    check("hdr_latency", {31'h0, bus_if.half_valid_o}, 32'h1);
    for (int i = 1; i < hold_cycles; i++) tick();
    cmd = 8'h00;
  endtask

  task automatic finish_event(input string tag);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || busy_o) && (n < 3000)) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
    end
    check({tag, "_cnt"}, {16'h0, event_cnt_o}, {16'h0, model_cnt});
    check({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin : main
    int n;
    rst = 1'b0;
    cmd = 8'h00;
    repeat (3) tick();
    check("rst_rd_en", {31'h0, bus_if.rd_en_o}, 32'h0);
    check("rst_valid", {31'h0, bus_if.half_valid_o}, 32'h0);
    check("rst_half", bus_if.event_half_o, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_cnt", {16'h0, event_cnt_o}, 32'h0);
    rst = 1'b1;
    repeat (2) tick();

    // Basic event, ready always high
    ready_mode = 0;
    load_pattern();
    begin_event(1);
    finish_event("ev1");
    check("ev1_reads", rd_count, NW);

    // Same event under 1-of-3 ready
    ready_mode = 1;
    load_pattern();
    begin_event(1);
    finish_event("ev2");

    // FIFO starvation after word 5
    ready_mode = 0;
    starve_at  = 6;
    load_pattern();
    begin_event(1);
    finish_event("ev3");
    starve_at  = -1;

    // Abort while HI of word 3 is stalled
    load_pattern();
    hold_after = 8;
    begin_event(1);
    n = 0;
    while ((acc_cnt < 8) && (n < 500)) begin
      tick();
      n++;
    end
    check("abort_reach_hi3", acc_cnt, 8);
    check("abort_pre_data", bus_if.event_half_o, 32'h0000_0003);
    cmd = CMD_ABORT;
    tick();
    cmd = 8'h00;
    check("abort_valid", {31'h0, bus_if.half_valid_o}, 32'h0);
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_rd_en", {31'h0, bus_if.rd_en_o}, 32'h0);
    exp_q.delete();
    model_cnt  = model_cnt - 16'h0001;
    check("abort_cnt", {16'h0, event_cnt_o}, {16'h0, model_cnt});
    hold_after = 1000;
    tick();
    load_pattern();
    begin_event(1);
    finish_event("ev_after_abort");

    // CMD_START held for 100 cycles gives one event
    load_random();
    begin_event(100);
    finish_event("ev_hold");
    repeat (10) tick();
    check("hold_idle_busy", {31'h0, busy_o}, 32'h0);

    // Counter wrap
    force dut.event_cnt_r = 16'hFFFF;
    tick();
    release dut.event_cnt_r;
    model_cnt = 16'hFFFF;
    tick();
    check("wrap_preset", {16'h0, event_cnt_o}, 32'h0000_FFFF);
    load_random();
    begin_event(1);
    finish_event("ev_wrap");
    load_random();
    begin_event(1);
    finish_event("ev_post_wrap");

    // Asynchronous reset in the middle of LO
    load_pattern();
    begin_event(1);
    n = 0;
    while ((dut.state_r != ST_LO) && (n < 500)) begin
      @(negedge clk_125);
      n++;
    end
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", {31'h0, bus_if.half_valid_o}, 32'h0);
    check("arst_rd_en", {31'h0, bus_if.rd_en_o}, 32'h0);
    check("arst_half", bus_if.event_half_o, 32'h0);
    check("arst_busy", {31'h0, busy_o}, 32'h0);
    check("arst_cnt", {16'h0, event_cnt_o}, 32'h0);
    exp_q.delete();
    model_cnt = 16'h0000;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    load_random();
    begin_event(1);
    finish_event("ev_after_rst");

    // Randomised events: random ready, random data, random starvation point
    ready_mode = 2;
    for (int e = 0; e < 3; e++) begin
      starve_at = $urandom_range(1, NW);
      load_random();
      begin_event(1);
      finish_event("ev_rand");
    end
    starve_at = -1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
